// File: rtl/ghash_pkg.sv
// Shared GHASH definitions: controller states, the GCM reduction constant and
// the GCM bit-order helper used by every GF(2^128) datapath.
package ghash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    SECOND,
    MUL,
    DONE
  } ghash_state_e;

  localparam logic [127:0] GCM_R = 128'hE1 << 120;

  typedef struct packed {
    logic [127:0] z;
    logic [127:0] v;
  } gf_slice_t;

  // GCM numbers coefficients from the MSB, so x^i lives at vector bit 127-i.
  function automatic logic [6:0] gf128_bit(input int i);
    return 7'(127 - i);
  endfunction

endpackage

// File: rtl/ghash_gf128_mul.sv
// Pipelined GF(2^128) multiplier, GCM bit order. Each of the MUL_LAT stages
// consumes one slice of the a operand with the shift-and-reduce algorithm.
module ghash_gf128_mul
  import ghash_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         start,
  input  logic [127:0] a,
  input  logic [127:0] b,
  output logic [127:0] p,
  output logic         p_valid
);

  localparam int BPS = (128 + MUL_LAT - 1) / MUL_LAT;

  logic [127:0]       zIn [MUL_LAT];
  logic [127:0]       vIn [MUL_LAT];
  logic [127:0]       xIn [MUL_LAT];
  gf_slice_t          sl  [MUL_LAT];
  logic [127:0]       z_q [MUL_LAT];
  logic [127:0]       v_q [MUL_LAT];
  logic [127:0]       x_q [MUL_LAT];
  logic [MUL_LAT-1:0] vld_q;

  function automatic gf_slice_t mulSlice(input logic [127:0] z, input logic [127:0] v,
                                         input logic [127:0] x, input int base);
    gf_slice_t r;
    r.z = z;
    r.v = v;
    for (int k = 0; k < BPS; k++) begin
      if (base + k < 128) begin
        if (x[gf128_bit(base + k)]) r.z = r.z ^ r.v;
        r.v = r.v[0] ? ((r.v >> 1) ^ GCM_R) : (r.v >> 1);
      end
    end
    return r;
  endfunction

  always_comb begin
    zIn[0] = '0;
    vIn[0] = b;
    xIn[0] = a;
    for (int s = 1; s < MUL_LAT; s++) begin
      zIn[s] = z_q[s-1];
      vIn[s] = v_q[s-1];
      xIn[s] = x_q[s-1];
    end
    for (int s = 0; s < MUL_LAT; s++) begin
      sl[s] = mulSlice(zIn[s], vIn[s], xIn[s], s * BPS);
    end
  end

  // Only the valid chain needs clearing; data registers are qualified by it.
  always_ff @(posedge clk) begin
    if (rst || flush) vld_q <= '0;
    else              vld_q <= (vld_q << 1) | MUL_LAT'(start);
    for (int s = 0; s < MUL_LAT; s++) begin
      z_q[s] <= sl[s].z;
      v_q[s] <= sl[s].v;
      x_q[s] <= xIn[s];
    end
  end

  assign p       = z_q[MUL_LAT-1];
  assign p_valid = vld_q[MUL_LAT-1];

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH accumulator: absorbs blocks in pairs with aggregated reduction
// Y' = (Y^X1)*H^2 ^ X2*H^1 and hands the final Y out as the tag.
module ghash_ctrl
  import ghash_pkg::*;
#(
  parameter int MUL_LAT = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] h1,
  input  logic [127:0] h2,
  input  logic         h_valid,
  input  logic [127:0] data_i,
  input  logic         data_valid_i,
  input  logic         data_last_i,
  output logic         data_ready_o,
  output logic [127:0] tag_o,
  output logic         tag_valid_o,
  input  logic         tag_ready_i,
  output logic         GHASH_done
);

  ghash_state_e state_q;
  logic [127:0] a_q, y_q, tag_q;
  logic         last_q, ready_q, tagValid_q, done_q;
  logic [3:0]   cnt_q;

  logic         inFirst, beatAccept, abortMsg, mulStart, mulDone;
  logic [127:0] m0A, m0B, m1A, p0, p1;
  logic         p0Valid, p1Valid;

  assign inFirst    = (state_q == FIRST);
  assign beatAccept = data_valid_i && ready_q && h_valid;
  assign abortMsg   = !h_valid && (state_q inside {FIRST, SECOND, MUL});
  assign mulStart   = beatAccept && ((inFirst && data_last_i) || state_q == SECOND);
  assign mulDone    = p0Valid && p1Valid && (cnt_q == 4'(MUL_LAT - 1));

  // A lone final block goes through h1 only; multiplying 0 keeps mul1 aligned.
  assign m0A = inFirst ? (y_q ^ data_i) : a_q;
  assign m0B = inFirst ? h1 : h2;
  assign m1A = inFirst ? '0 : data_i;

  ghash_gf128_mul #(.MUL_LAT(MUL_LAT)) u_mul0 (
    .clk(clk), .rst(rst), .flush(abortMsg), .start(mulStart),
    .a(m0A), .b(m0B), .p(p0), .p_valid(p0Valid)
  );

  ghash_gf128_mul #(.MUL_LAT(MUL_LAT)) u_mul1 (
    .clk(clk), .rst(rst), .flush(abortMsg), .start(mulStart),
    .a(m1A), .b(h1), .p(p1), .p_valid(p1Valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      y_q        <= '0;
      tag_q      <= '0;
      last_q     <= 1'b0;
      ready_q    <= 1'b0;
      tagValid_q <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (abortMsg) begin
        state_q <= IDLE;
        y_q     <= '0;
        ready_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (h_valid) begin
              state_q <= FIRST;
              ready_q <= 1'b1;
            end
          end
          FIRST: begin
            if (beatAccept) begin
              a_q <= y_q ^ data_i;
              if (data_last_i) begin
                last_q  <= 1'b1;
                state_q <= MUL;
                ready_q <= 1'b0;
              end else begin
                state_q <= SECOND;
              end
            end
          end
          SECOND: begin
            if (beatAccept) begin
              last_q  <= data_last_i;
              state_q <= MUL;
              ready_q <= 1'b0;
            end
          end
          MUL: begin
            if (mulDone) begin
              y_q   <= p0 ^ p1;
              cnt_q <= '0;
              if (last_q) begin
                state_q <= DONE;
              end else begin
                state_q <= FIRST;
                ready_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          DONE: begin
            // The tag is presented one cycle after entering DONE and held there.
            if (tagValid_q && tag_ready_i) begin
              tagValid_q <= 1'b0;
              done_q     <= 1'b1;
              y_q        <= '0;
              state_q    <= IDLE;
            end else begin
              tagValid_q <= 1'b1;
              tag_q      <= y_q;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign data_ready_o = ready_q;
  assign tag_o        = tag_q;
  assign tag_valid_o  = tagValid_q;
  assign GHASH_done   = done_q;

endmodule

// File: tb/tb_ghash_ctrl.sv
// Scoreboard bench for ghash_ctrl: stimulus pushes expected tags, a monitor
// pops them on every tag handshake and also watches latency and GHASH_done.
module tb_ghash_ctrl;

  localparam int MUL_LAT = 5;
  localparam logic [127:0] ID = 128'h8000_0000_0000_0000_0000_0000_0000_0000;

  logic         clk;
  logic         rst;
  logic [127:0] h1, h2;
  logic         h_valid;
  logic [127:0] data_i;
  logic         data_valid_i;
  logic         data_last_i;
  logic         data_ready_o;
  logic [127:0] tag_o;
  logic         tag_valid_o;
  logic         tag_ready_i;
  logic         GHASH_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastAcceptEdge = 0;
  int tagHold = 0;
  bit tagRandom = 0;

  logic [127:0] sbQ[$];
  logic [127:0] msgQ[$];

  ghash_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .h1(h1), .h2(h2), .h_valid(h_valid),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_last_i(data_last_i),
    .data_ready_o(data_ready_o), .tag_o(tag_o), .tag_valid_o(tag_valid_o),
    .tag_ready_i(tag_ready_i), .GHASH_done(GHASH_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference multiply: plain polynomial product in natural bit order, then
  // folding the upper half back with x^128 = x^7 + x^2 + x + 1.
  function automatic logic [127:0] gfMul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] px, py, lo, r;
    logic [255:0] acc, sh, hi;
    px  = {<<{x}};
    py  = {<<{y}};
    acc = '0;
    sh  = {128'b0, py};
    for (int i = 0; i < 128; i++) begin
      if (px[0]) acc = acc ^ sh;
      px = px >> 1;
      sh = sh << 1;
    end
    for (int k = 0; k < 2; k++) begin
      hi  = {128'b0, acc[255:128]};
      acc = {128'b0, acc[127:0]} ^ hi ^ (hi << 1) ^ (hi << 2) ^ (hi << 7);
    end
    lo = acc[127:0];
    r  = {<<{lo}};
    return r;
  endfunction

  function automatic logic [127:0] serialGhash(input logic [127:0] hk);
    logic [127:0] y;
    y = '0;
    foreach (msgQ[i]) y = gfMul(y ^ msgQ[i], hk);
    return y;
  endfunction

  task automatic finishRun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic sendBeat(input logic [127:0] blk, input logic last, input int stallPct);
    int waitCnt;
    while (int'($urandom_range(0, 99)) < stallPct) begin
      data_valid_i = 1'b0;
      @(posedge clk); #1;
    end
    data_i       = blk;
    data_last_i  = last;
    data_valid_i = 1'b1;
    waitCnt      = 0;
    forever begin
      @(negedge clk);
      if (data_ready_o) break;
      @(posedge clk); #1;
      waitCnt++;
      if (waitCnt > 1000) begin
        checks++;
        errors++;
        $display("[TB] FAIL beat accept timeout: data_ready_o=%0b, required 1", data_ready_o);
        finishRun();
      end
    end
    lastAcceptEdge = cyc + 1;
    @(posedge clk); #1;
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
  endtask

  task automatic applyStimulus(input logic [127:0] hk, input logic [127:0] h2k,
                               input logic [127:0] expTag, input int stallPct);
    int waitCnt;
    sbQ.push_back(expTag);
    h1      = hk;
    h2      = h2k;
    h_valid = 1'b1;
    foreach (msgQ[i]) sendBeat(msgQ[i], (i == msgQ.size() - 1), stallPct);
    waitCnt = 0;
    forever begin
      @(negedge clk);
      if (GHASH_done) break;
      waitCnt++;
      if (waitCnt > 2000) begin
        checks++;
        errors++;
        $display("[TB] FAIL GHASH_done timeout: tag_valid_o=%0b, required a done pulse", tag_valid_o);
        finishRun();
      end
    end
    // The key generator clears on GHASH_done, so h_valid falls right away.
    h_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    tag_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (tagHold > 0 && tag_valid_o) begin
        tag_ready_i = 1'b0;
        tagHold--;
      end else if (tagRandom) begin
        tag_ready_i = ($urandom_range(0, 2) != 0);
      end else begin
        tag_ready_i = 1'b1;
      end
    end
  end

  initial begin
    logic         prevValid, prevReady, prevTake;
    logic [127:0] prevTag, expTag;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevTake  = 1'b0;
    prevTag   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (prevValid && !prevReady) begin
          checkOutput("tag_valid_o held", tag_valid_o, 1'b1);
          if (tag_valid_o) checkOutput("tag_o held", tag_o, prevTag);
        end
        if (prevTake) checkOutput("tag_valid_o drop", tag_valid_o, 1'b0);
        if (tag_valid_o && !prevValid)
          checkOutput("tag latency", cyc - lastAcceptEdge, MUL_LAT + 1);
        if (prevTake || GHASH_done) checkOutput("GHASH_done pulse", GHASH_done, prevTake);
        if (tag_valid_o && tag_ready_i) begin
          if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected tag: got %h, required no tag", tag_o);
          end else begin
            expTag = sbQ.pop_front();
            checkOutput("tag_o", tag_o, expTag);
          end
        end
        prevTake  = tag_valid_o && tag_ready_i;
        prevValid = tag_valid_o;
        prevReady = tag_ready_i;
        prevTag   = tag_o;
      end
    end
  end

  initial begin
    #600000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    finishRun();
  end

  initial begin
    logic [127:0] x1, x2, hk, h2k, nh, blk;
    logic         sawTag, sawDone;
    int           len;

    rst          = 1'b1;
    h1           = '0;
    h2           = '0;
    h_valid      = 1'b0;
    data_i       = '0;
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset data_ready_o", data_ready_o, 1'b0);
    checkOutput("reset tag_valid_o", tag_valid_o, 1'b0);
    checkOutput("reset tag_o", tag_o, '0);
    checkOutput("reset GHASH_done", GHASH_done, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] identity key, two blocks");
    x1 = 128'h0123456789abcdef0123456789abcdef;
    x2 = 128'hffffffffffffffff0000000000000000;
    msgQ = '{x1, x2};
    applyStimulus(ID, ID, x1 ^ x2, 0);

    $display("[TB] identity key, odd block count");
    msgQ = '{128'h1, 128'h2, 128'h4};
    applyStimulus(ID, ID, 128'h7, 0);

    $display("[TB] NIST GCM test case 2");
    nh   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    msgQ = '{128'h0388dace60b6a392f328c2b971b2fe78, 128'h00000000000000000000000000000080};
    applyStimulus(nh, gfMul(nh, nh), 128'hf38cbb1ad69223dcc3457ae5b6b0f885, 0);

    $display("[TB] tag backpressure");
    tagHold = 20;
    msgQ = '{128'h9, 128'ha};
    applyStimulus(ID, ID, 128'h3, 0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle data_ready_o", data_ready_o, 1'b0);
    end
    @(posedge clk); #1;

    $display("[TB] abort during multiply");
    h1      = ID;
    h2      = ID;
    h_valid = 1'b1;
    sendBeat(128'hdead, 1'b0, 0);
    sendBeat(128'hbeef, 1'b0, 0);
    @(posedge clk); #1;
    h_valid = 1'b0;
    sawTag  = 1'b0;
    sawDone = 1'b0;
    repeat (MUL_LAT + 6) begin
      @(negedge clk);
      sawTag  = sawTag | tag_valid_o;
      sawDone = sawDone | GHASH_done;
    end
    checkOutput("abort no tag_valid_o", sawTag, 1'b0);
    checkOutput("abort no GHASH_done", sawDone, 1'b0);
    checkOutput("abort data_ready_o", data_ready_o, 1'b0);
    @(posedge clk); #1;
    msgQ = '{128'h5, 128'h3};
    applyStimulus(ID, ID, 128'h6, 0);

    $display("[TB] random messages with stalls");
    tagRandom = 1'b1;
    for (int m = 0; m < 200; m++) begin
      len = int'($urandom_range(1, 16));
      hk  = {$urandom, $urandom, $urandom, $urandom};
      h2k = gfMul(hk, hk);
      msgQ.delete();
      for (int i = 0; i < len; i++) begin
        blk = {$urandom, $urandom, $urandom, $urandom};
        msgQ.push_back(blk);
      end
      applyStimulus(hk, h2k, serialGhash(hk), 30);
    end
    tagRandom = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", 128'(sbQ.size()), '0);
    finishRun();
  end

endmodule
